// File: rtl/day_trading_pkg.sv
// Shared types and action codes for the day-trading advisor family.
package day_trading_pkg;

  // Trend classes produced by the window classifier.
  typedef enum logic [2:0] {
    STAGNANT   = 3'd0,
    INC_LOT    = 3'd1,
    DEC_LOT    = 3'd2,
    INC_LITTLE = 3'd3,
    DEC_LITTLE = 3'd4
  } trend_t;

  // Advisor control states.
  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_EVAL    = 2'd1,
    S_DECIDE  = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  localparam logic [15:0] ACT_FAIL            = 16'd0;
  localparam logic [15:0] ACT_SELL_ALL        = 16'd1;
  localparam logic [15:0] ACT_STAY_OUT        = 16'd2;
  localparam logic [15:0] ACT_BUY_MORE        = 16'd3;
  localparam logic [15:0] ACT_BUY_LOT         = 16'd4;
  localparam logic [15:0] ACT_SELL_HALF       = 16'd5;
  localparam logic [15:0] ACT_BUY_LITTLE_MORE = 16'd6;
  localparam logic [15:0] ACT_BUY_LITTLE      = 16'd7;
  localparam logic [15:0] ACT_HOLD            = 16'd8;

  // Maps a trend and the ownership flag to the advice code; an encoding
  // outside the enum reports a failed calculation.
  function automatic logic [15:0] action_code(input trend_t trend, input logic owned);
    logic [15:0] code;
    case (trend)
      INC_LOT:    code = owned ? ACT_SELL_ALL        : ACT_STAY_OUT;
      DEC_LOT:    code = owned ? ACT_BUY_MORE        : ACT_BUY_LOT;
      INC_LITTLE: code = owned ? ACT_SELL_HALF       : ACT_STAY_OUT;
      DEC_LITTLE: code = owned ? ACT_BUY_LITTLE_MORE : ACT_BUY_LITTLE;
      STAGNANT:   code = owned ? ACT_HOLD            : ACT_BUY_LITTLE;
      default:    code = ACT_FAIL;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/price_window.sv
// Price window: shift register of the last WINDOW samples (slot 0 = oldest)
// with a fill count that saturates at WINDOW.
module price_window #(
  parameter  int PRICE_W = 5,
  parameter  int WINDOW  = 3,
  localparam int CNT_W   = $clog2(WINDOW + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clear,
  input  logic                       i_shift,
  input  logic [PRICE_W-1:0]         i_price,
  output logic [WINDOW*PRICE_W-1:0]  o_window,
  output logic [CNT_W-1:0]           o_count,
  output logic                       o_full
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WINDOW);

  logic [WINDOW*PRICE_W-1:0] r_win;
  logic [CNT_W-1:0]          r_count;

  // Newest sample enters the top slot; the oldest falls off slot 0.
  always_ff @(posedge clk) begin
    if (i_shift) begin
      r_win <= {i_price, r_win[WINDOW*PRICE_W-1:PRICE_W]};
    end
  end

  // Fill count; reset or clear discards whatever partial window was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_shift && (r_count != FULL_CNT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_window = r_win;
  assign o_count  = r_count;
  assign o_full   = (r_count == FULL_CNT);

endmodule

// File: rtl/trend_advisor.sv
// Trend advisor top: collects a price window, classifies its trend and
// delivers an action code over a valid/ready handshake.
module trend_advisor
  import day_trading_pkg::*;
#(
  parameter int PRICE_W = 5,
  parameter int WINDOW  = 3,
  parameter int SLIDING = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PRICE_W-1:0] in_price,
  input  logic               in_owned,
  output logic               action_valid,
  input  logic               action_ready,
  output logic [15:0]        action_out
);

  localparam int               CNT_W    = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  state_t                    r_state;
  logic                      r_in_ready;
  logic                      r_action_valid;
  logic [15:0]               r_action_out;
  trend_t                    r_trend;
  logic                      r_owned;

  logic                      w_accept;
  logic                      w_fill;
  logic                      w_clear;
  logic [WINDOW*PRICE_W-1:0] w_window;
  logic [CNT_W-1:0]          w_count;
  logic                      w_full;
  logic                      w_all_up;
  logic                      w_all_dn;
  logic signed [PRICE_W:0]   w_net;
  trend_t                    w_trend;

  // r_in_ready is only ever high in COLLECT, so it alone qualifies a transfer.
  assign w_accept = in_valid && r_in_ready;
  // The accept that completes the window: either the last missing sample, or
  // any sample once the window is already full (sliding mode).
  assign w_fill   = w_accept && (w_full || (w_count == LAST_CNT));
  // Block mode starts an empty window after each delivered advice.
  assign w_clear  = (SLIDING == 0) && (r_state == S_OUTPUT) && action_ready;

  price_window #(
    .PRICE_W (PRICE_W),
    .WINDOW  (WINDOW)
  ) u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .i_shift  (w_accept),
    .i_price  (in_price),
    .o_window (w_window),
    .o_count  (w_count),
    .o_full   (w_full)
  );

  // Trend classifier over the held window; first matching rule wins.
  always_comb begin
    w_all_up = 1'b1;
    w_all_dn = 1'b1;
    for (int i = 0; i < WINDOW - 1; i++) begin
      if (!(w_window[(i+1)*PRICE_W +: PRICE_W] > w_window[i*PRICE_W +: PRICE_W])) w_all_up = 1'b0;
      if (!(w_window[(i+1)*PRICE_W +: PRICE_W] < w_window[i*PRICE_W +: PRICE_W])) w_all_dn = 1'b0;
    end
    w_net = $signed({1'b0, w_window[(WINDOW-1)*PRICE_W +: PRICE_W]})
          - $signed({1'b0, w_window[0 +: PRICE_W]});
    if (w_all_up)       w_trend = INC_LOT;
    else if (w_all_dn)  w_trend = DEC_LOT;
    else if (w_net > 0) w_trend = INC_LITTLE;
    else if (w_net < 0) w_trend = DEC_LITTLE;
    else                w_trend = STAGNANT;
  end

  // Control FSM with registered handshake outputs, trend and ownership.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_COLLECT;
      r_in_ready     <= 1'b0;
      r_action_valid <= 1'b0;
      r_action_out   <= '0;
      r_trend        <= STAGNANT;
      r_owned        <= 1'b0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            // Block windows keep the owner flag of their first sample;
            // sliding windows follow the newest sample.
            if ((SLIDING != 0) || (w_count == '0)) r_owned <= in_owned;
            if (w_fill) begin
              r_in_ready <= 1'b0;
              r_state    <= S_EVAL;
            end
          end
        end
        S_EVAL: begin
          r_trend <= w_trend;
          r_state <= S_DECIDE;
        end
        S_DECIDE: begin
          r_action_out   <= action_code(r_trend, r_owned);
          r_action_valid <= 1'b1;
          r_state        <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (action_ready) begin
            r_action_valid <= 1'b0;
            r_action_out   <= '0;
            r_in_ready     <= 1'b1;
            r_state        <= S_COLLECT;
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign action_valid = r_action_valid;
  assign action_out   = r_action_out;

endmodule

// File: tb/tb_trend_advisor.sv
// Bench for trend_advisor: three configurations (block W=3, sliding W=3,
// block 8-bit W=8) share one stimulus path selected by sel; a queue of
// expected advices is filled as samples are accepted and drained by a monitor.
module tb_trend_advisor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        tb_valid;
  logic [7:0]  tb_price;
  logic        tb_owned;
  logic        tb_ack;

  logic [2:0]  in_valid_v, in_ready_v, act_valid_v, act_ready_v;
  logic [15:0] act_out_v [3];

  logic        obs_in_ready, obs_act_valid;
  logic [15:0] obs_act_out;

  int          n_vec = 0;
  int          n_err = 0;
  int          hist[$];
  bit          own[$];
  int          exp_q[$];
  int          cfg_w;
  bit          cfg_slide;

  always #5 clk = ~clk;

  always_comb begin
    in_valid_v  = 3'b000;
    act_ready_v = 3'b000;
    in_valid_v[sel]  = tb_valid;
    act_ready_v[sel] = tb_ack;
    obs_in_ready  = in_ready_v[sel];
    obs_act_valid = act_valid_v[sel];
    obs_act_out   = act_out_v[sel];
  end

  trend_advisor #(.PRICE_W(5), .WINDOW(3), .SLIDING(0)) u_blk (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_price(tb_price[4:0]), .in_owned(tb_owned), .action_valid(act_valid_v[0]),
    .action_ready(act_ready_v[0]), .action_out(act_out_v[0]));

  trend_advisor #(.PRICE_W(5), .WINDOW(3), .SLIDING(1)) u_sld (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_price(tb_price[4:0]), .in_owned(tb_owned), .action_valid(act_valid_v[1]),
    .action_ready(act_ready_v[1]), .action_out(act_out_v[1]));

  trend_advisor #(.PRICE_W(8), .WINDOW(8), .SLIDING(0)) u_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_price(tb_price), .in_owned(tb_owned), .action_valid(act_valid_v[2]),
    .action_ready(act_ready_v[2]), .action_out(act_out_v[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Reference advice for the window currently held in hist.
  function automatic int ref_code(input bit o);
    int  w   = hist.size();
    bit  up  = 1'b1;
    bit  dn  = 1'b1;
    int  net;
    for (int i = 0; i < w - 1; i++) begin
      if (!(hist[i+1] > hist[i])) up = 1'b0;
      if (!(hist[i+1] < hist[i])) dn = 1'b0;
    end
    net = hist[w-1] - hist[0];
    if (up)           return o ? 1 : 2;
    else if (dn)      return o ? 3 : 4;
    else if (net > 0) return o ? 5 : 2;
    else if (net < 0) return o ? 6 : 7;
    else              return o ? 8 : 7;
  endfunction

  task automatic model_accept(input int p, input bit o);
    hist.push_back(p);
    own.push_back(o);
    if (cfg_slide) begin
      if (hist.size() > cfg_w) begin
        void'(hist.pop_front());
        void'(own.pop_front());
      end
      if (hist.size() == cfg_w) exp_q.push_back(ref_code(own[own.size()-1]));
    end else if (hist.size() == cfg_w) begin
      exp_q.push_back(ref_code(own[0]));
      hist.delete();
      own.delete();
    end
  endtask

  task automatic send(input int p, input bit o);
    int n = 0;
    tb_price = 8'(p);
    tb_owned = o;
    tb_valid = 1'b1;
    while (!obs_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!obs_in_ready) begin
      chk("accept_timeout", 0, 1);
      tb_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 tb_valid = 1'b0;
    model_accept(p, o);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic select(input logic [1:0] s, input int w, input bit slide);
    @(negedge clk);
    sel = s;
    cfg_w = w;
    cfg_slide = slide;
    hist.delete();
    own.delete();
  endtask

  // Consumer side: every advice handed over is checked against the queue.
  always @(negedge clk) begin
    if (rst_n && obs_act_valid && tb_ack) begin
      if (exp_q.size() == 0) chk("spurious_advice", 1, 0);
      else                   chk("advice", obs_act_out, exp_q.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int t3p [4][3];
    int t3o [4];
    t3p = '{'{9, 5, 3}, '{5, 3, 7}, '{5, 7, 3}, '{4, 4, 4}};
    t3o = '{0, 1, 0, 1};
    rst_n = 1'b0; sel = 2'd0; tb_valid = 1'b0; tb_price = '0; tb_owned = 1'b0; tb_ack = 1'b1;
    cfg_w = 3; cfg_slide = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", obs_in_ready, 0);
    chk("rst_act_valid", obs_act_valid, 0);
    chk("rst_act_out", obs_act_out, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("release_in_ready", obs_in_ready, 0);
    @(posedge clk);
    #1 chk("first_cycle_in_ready", obs_in_ready, 1);

    // Reset mid-collection discards the partial window
    send(3, 1);
    send(5, 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", obs_in_ready, 0);
    chk("midrst_act_valid", obs_act_valid, 0);
    chk("midrst_act_out", obs_act_out, 0);
    hist.delete();
    own.delete();
    @(negedge clk) rst_n = 1'b1;
    send(7, 0);
    send(6, 0);
    send(5, 0);
    wait_drain();

    // Block mode latency: valid appears only after the second edge
    send(3, 1);
    send(5, 0);
    send(9, 0);
    chk("lat_edge0_valid", obs_act_valid, 0);
    @(posedge clk);
    #1 chk("lat_edge1_valid", obs_act_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_edge2_valid", obs_act_valid, 1);
    chk("lat_edge2_code", obs_act_out, 1);
    wait_drain();

    // Block mode classification table
    for (int k = 0; k < 4; k++) begin
      send(t3p[k][0], t3o[k][0]);
      send(t3p[k][1], 1'b0);
      send(t3p[k][2], 1'b1);
    end
    wait_drain();

    // Backpressure: advice held, input stalled, pending sample not lost
    tb_ack = 1'b0;
    send(10, 0);
    send(20, 1);
    send(30, 1);
    tb_price = 8'd31; tb_owned = 1'b1; tb_valid = 1'b1;
    for (int n = 0; n < 20 && !obs_act_valid; n++) @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("bp_valid", obs_act_valid, 1);
      chk("bp_code", obs_act_out, 2);
      chk("bp_in_ready", obs_in_ready, 0);
    end
    tb_ack = 1'b1;
    send(31, 1);
    send(30, 0);
    send(29, 0);
    wait_drain();

    // Sliding window stream
    select(2'd1, 3, 1'b1);
    send(1, 0);
    send(2, 0);
    send(3, 0);
    send(2, 0);
    send(1, 0);
    wait_drain();

    // Wide price, long window
    select(2'd2, 8, 1'b0);
    for (int i = 0; i < 8; i++) send(i * 36, 1);
    for (int i = 0; i < 8; i++) send(255, 1);
    for (int i = 0; i < 7; i++) send(255, 1);
    send(0, 0);
    wait_drain();

    chk("leftover_expected", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
